// File: rtl/insn_queue_pkg.sv
// Shared CPU-side definitions: default address/data widths and the queue entry layout.
// Entry layout is {illegal, pc, insn}, packed MSB first.
package insn_queue_pkg;

    localparam int AW  = 30;
    localparam int DW  = 32;
    localparam int PCW = AW + 2;

    typedef struct packed {
        logic           illegal;
        logic [PCW-1:0] pc;
        logic [DW-1:0]  insn;
    } q_entry_t;

    localparam int ENTRY_W = $bits(q_entry_t);

    // Entry width for non-default address/data widths
    function automatic int entry_width(input int aw, input int dw);
        return 1 + aw + 2 + dw;
    endfunction

endpackage

// File: rtl/insn_queue_if.sv
// Prefetch -> queue -> decode bundle, plus the CPU flush requests.
// slave is the queue side; master is the prefetch/decode/CPU side.
interface insn_queue_if
    import insn_queue_pkg::*;
#(
    parameter int ADDRESS_WIDTH = AW,
    parameter int DATA_WIDTH    = DW,
    parameter int LGDEPTH       = 2
) ();

    logic                       i_new_pc;
    logic                       i_clear_cache;
    logic                       i_pf_valid;
    logic [DATA_WIDTH-1:0]      i_pf_insn;
    logic [ADDRESS_WIDTH+1:0]   i_pf_pc;
    logic                       i_pf_illegal;
    logic                       o_pf_ready;
    logic                       o_valid;
    logic [DATA_WIDTH-1:0]      o_insn;
    logic [ADDRESS_WIDTH+1:0]   o_pc;
    logic                       o_illegal;
    logic                       i_dcd_ready;
    logic [LGDEPTH:0]           o_fill;

    modport slave (
        input  i_new_pc, i_clear_cache,
        input  i_pf_valid, i_pf_insn, i_pf_pc, i_pf_illegal,
        output o_pf_ready,
        output o_valid, o_insn, o_pc, o_illegal,
        input  i_dcd_ready,
        output o_fill
    );

    modport master (
        output i_new_pc, i_clear_cache,
        output i_pf_valid, i_pf_insn, i_pf_pc, i_pf_illegal,
        input  o_pf_ready,
        input  o_valid, o_insn, o_pc, o_illegal,
        output i_dcd_ready,
        input  o_fill
    );

endinterface

// File: rtl/insn_queue_sfifo_mem.sv
// Register-array FIFO storage: one synchronous write port, one asynchronous read port.
// Latency: write visible on read port the cycle after the write edge.
// Backpressure: none here; the owner decides when to write.
module insn_queue_sfifo_mem #(
    parameter int WIDTH   = 65,
    parameter int LGDEPTH = 2
) (
    input  logic               i_clk,
    input  logic               i_wr_en,
    input  logic [LGDEPTH-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]   i_wr_dat,
    input  logic [LGDEPTH-1:0] i_rd_addr,
    output logic [WIDTH-1:0]   o_rd_dat
);

    logic [WIDTH-1:0] mem [1 << LGDEPTH];

    // Storage is not reset; the owner masks reads while empty
    always_ff @(posedge i_clk) begin
        if (i_wr_en)
            mem[i_wr_addr] <= i_wr_dat;
    end

    assign o_rd_dat = mem[i_rd_addr];

endmodule

// File: rtl/insn_queue.sv
// Instruction FIFO between prefetch and decode, with flush on branch/cache clear and halt on bus error.
// Latency: one cycle from accepted push to o_valid; head is first-word fall-through.
// Backpressure: o_pf_ready = !full from registered fill only; i_dcd_ready gates pops.
module insn_queue
    import insn_queue_pkg::*;
#(
    parameter int ADDRESS_WIDTH = AW,
    parameter int DATA_WIDTH    = DW,
    parameter int LGDEPTH       = 2
) (
    input  logic         i_clk,
    input  logic         i_reset,
    insn_queue_if.slave  q
);

    localparam int               EW        = entry_width(ADDRESS_WIDTH, DATA_WIDTH);
    localparam logic [LGDEPTH:0] DEPTH_CNT = (LGDEPTH+1)'(1 << LGDEPTH);
    localparam logic [LGDEPTH:0] PTR_ONE   = (LGDEPTH+1)'(1);

    logic [LGDEPTH:0] wr_ptr, rd_ptr, fill;
    logic             halt;
    logic             flush, full, empty, push, pop;
    logic [EW-1:0]    wr_dat, rd_dat;
    logic             rd_illegal;

    // Pointers carry one extra bit so full and empty stay distinguishable
    assign fill  = wr_ptr - rd_ptr;
    assign full  = (fill == DEPTH_CNT);
    assign empty = (fill == '0);
    assign flush = i_reset | q.i_new_pc | q.i_clear_cache;

    assign push = q.i_pf_valid & ~full & ~flush & ~halt;
    assign pop  = ~empty & q.i_dcd_ready & ~flush;

    always_ff @(posedge i_clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            halt   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            // Nothing after a bus-error word is meaningful until the CPU redirects
            if (push && q.i_pf_illegal)
                halt <= 1'b1;
        end
    end

    assign wr_dat = {q.i_pf_illegal, q.i_pf_pc, q.i_pf_insn};

    insn_queue_sfifo_mem #(
        .WIDTH   (EW),
        .LGDEPTH (LGDEPTH)
    ) u_mem (
        .i_clk     (i_clk),
        .i_wr_en   (push),
        .i_wr_addr (wr_ptr[LGDEPTH-1:0]),
        .i_wr_dat  (wr_dat),
        .i_rd_addr (rd_ptr[LGDEPTH-1:0]),
        .o_rd_dat  (rd_dat)
    );

    assign {rd_illegal, q.o_pc, q.o_insn} = rd_dat;

    // Unwritten storage must not report a bus error
    assign q.o_illegal  = rd_illegal & ~empty;
    assign q.o_valid    = ~empty;
    assign q.o_pf_ready = ~full;
    assign q.o_fill     = fill;

endmodule

// File: doc/insn_queue.md
Name: insn_queue

Overview:
- Small instruction FIFO between the single-word prefetch and the instruction decoder.
- Accepts {insn, pc, illegal} words from prefetch and drives prefetch's stall-release (i_stalled_n) input.
- Presents words to decode with a valid/ready handshake.
- Flushes on branch (new PC) or cache clear, so decode never sees stale words. Decouples decode stalls from bus fetch cadence.

Parameters:
- ADDRESS_WIDTH, 30, word-address width; PC width is ADDRESS_WIDTH+2.
- DATA_WIDTH, 32, instruction width.
- LGDEPTH, 2, log2 of queue depth (default depth 4); legal range 1..5.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_new_pc  in  1  CPU branch request; flush
- i_clear_cache  in  1  CPU cache clear; flush
- i_pf_valid  in  1  prefetch word valid
- i_pf_insn  in  DATA_WIDTH  prefetch instruction
- i_pf_pc  in  ADDRESS_WIDTH+2  address of that instruction
- i_pf_illegal  in  1  word came from a bus error
- o_pf_ready  out  1  accept from prefetch; wired to prefetch i_stalled_n
- o_valid  out  1  head entry valid to decode
- o_insn  out  DATA_WIDTH  head instruction
- o_pc  out  ADDRESS_WIDTH+2  head PC
- o_illegal  out  1  head entry is a bus-error word
- i_dcd_ready  in  1  decode accepts head this cycle
- o_fill  out  LGDEPTH+1  current occupancy

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- Storage: array of 2^LGDEPTH entries {illegal, pc, insn}. Read and write pointers are LGDEPTH+1 bits.
  - fill = wr_ptr - rd_ptr (modulo arithmetic).
  - full when fill == 2^LGDEPTH; empty when fill == 0.
  - Pointers wrap naturally; no explicit wrap logic.
- Flush condition F = i_reset | i_new_pc | i_clear_cache. On F, at the next edge:
  - both pointers are 0 and the sticky halt flag is 0;
  - any push or pop presented in the same cycle is discarded.
- Reset values: o_valid=0, o_fill=0, o_illegal=0; o_pf_ready=1 once reset deasserts.
- Push: push = i_pf_valid & o_pf_ready & !F & !halt. Writes at wr_ptr and increments wr_ptr.
- o_pf_ready = !full, computed from registered fill only. It has no combinational path from i_dcd_ready. When full, no push occurs even if a pop happens in the same cycle.
- Pop: pop = o_valid & i_dcd_ready & !F. Increments rd_ptr.
- Outputs: o_valid = !empty. o_insn, o_pc and o_illegal are read asynchronously from entry rd_ptr (first-word fall-through).
  - A word pushed at edge N is visible on o_valid after edge N, i.e. one cycle of latency.
  - Outputs hold stable while o_valid & !i_dcd_ready.
- Simultaneous push and pop (not full): fill is unchanged and both pointers advance.
- Illegal handling: pushing an entry with i_pf_illegal=1 sets sticky halt.
  - While halt is set, further pushes are dropped and o_pf_ready is still reported as !full.
  - The illegal entry drains to decode normally. halt clears only on F.
- o_insn/o_pc/o_illegal are don't-care when o_valid=0.
- Queue never reorders. PC values are passed through unchanged and are not checked for sequence.

Decomposition:
- Shared package (cpu_defs): AW/DW defaults, PC-width constant (AW+2), and the queue entry field layout {illegal, pc, insn} with its total width.
- Single module. An optional sub-module sfifo_mem (dual-pointer register-array memory with async read) is natural for reuse by the data-side load queue.
- Control logic (pointers, halt, flush) stays in insn_queue.

Test Plan:
- Reset then 4 pushes: pc 0x100, 0x104, 0x108, 0x10C with i_dcd_ready=0 → o_fill=4, o_pf_ready=0 after the 4th edge; a 5th offered word is not accepted.
- Fill to 4, then i_dcd_ready=1 for 4 cycles → o_pc sequence 0x100, 0x104, 0x108, 0x10C; o_valid=0 after the last pop; o_fill=0.
- Continuous stream with i_pf_valid=1 and i_dcd_ready=1 → steady throughput of 1 word/cycle after 1-cycle latency; o_fill holds at 1.
- Queue at 3 entries, assert i_new_pc with a simultaneous push and pop → next cycle o_fill=0, o_valid=0. Next push pc 0x2000 appears on o_pc one cycle later.
- Push illegal word at pc 0x300 (i_pf_illegal=1), then offer pc 0x304 → 0x304 is dropped. Decode sees o_valid=1, o_illegal=1, o_pc=0x300. After i_clear_cache, a push of 0x304 is accepted.
- Push 6 words with alternating pops (LGDEPTH=2) → pointers wrap past index 3; output order is preserved and o_fill never exceeds 4.
